pipeline_ctrl: RTL
==================

PIPELINE_CTRL -- requirements
Module: pipeline_ctrl

Interface
REQ-001 Parameter CNT_W, default 32, width of the performance counters.
REQ-002 Clock and reset: one clock; reset is asynchronous and active-high.
REQ-003 clk  in  1  rising-edge clock.
REQ-004 rst  in  1  asynchronous active-high reset.
REQ-005 imem_resp  in  1  fetch data valid this cycle.
REQ-006 dmem_active  in  1  MEM stage holds a load/store.
REQ-007 dmem_resp  in  1  data access completes this cycle.
REQ-008 br_taken_ex  in  1  single-cycle pulse: EX resolved a taken branch/jump.
REQ-009 ex_is_load  in  1  EX stage instruction is a load.
REQ-010 ex_rd / id_rs1 / id_rs2  in  5 each  register indices.
REQ-011 clr_cnt  in  1  synchronous clear of both counters.
REQ-012 pc_load, if_id_load, id_ex_load, ex_mem_load, mem_wb_load  out  1 each  stage register enables.
REQ-013 if_id_flush, id_ex_flush  out  1 each  load NOP (0x00000013) instead of input; meaningful only with matching load=1.
REQ-014 stall_cnt, flush_cnt  out  CNT_W each  saturating event counters.
REQ-015 busy  out  1  high while in MEM_WAIT.

Function
REQ-016 mem_stall = ~imem_resp | (dmem_active & ~dmem_resp), combinational.
REQ-017 load_use = ex_is_load & ex_rd!=0 & (ex_rd==id_rs1 | ex_rd==id_rs2).
REQ-018 FSM states RUN and MEM_WAIT; one register pending_redirect.
REQ-019 RUN, mem_stall=0, no redirect, no load_use: all loads 1, all flushes 0.
REQ-020 RUN, mem_stall=1: all loads 0, flushes 0; next state MEM_WAIT, same cycle.
REQ-021 MEM_WAIT, mem_stall=1: all loads 0; remain.
REQ-022 MEM_WAIT, mem_stall=0: all loads 1; next state RUN.
REQ-023 br_taken_ex while mem_stall=1 (either state): set pending_redirect; no flush that cycle.
REQ-024 Redirect applies on first cycle with mem_stall=0 where br_taken_ex=1 or pending_redirect=1: all loads 1, if_id_flush=1, id_ex_flush=1; pending_redirect cleared; flush_cnt +1 once per redirect.
REQ-025 Priority: mem_stall > redirect > load_use.
REQ-026 load_use (no mem_stall, no redirect): pc_load=0, if_id_load=0, id_ex_load=1 with id_ex_flush=1, ex_mem_load=1, mem_wb_load=1; single bubble, no state change.
REQ-027 stall_cnt +1 each cycle pc_load=0 outside reset.
REQ-028 Counters saturate at 2^CNT_W-1, no wrap; clr_cnt zeroes both next edge, overriding same-cycle increment.
REQ-029 All outputs except counters and busy are combinational from inputs and state; zero latency.

Reset
REQ-030 rst asserted: state=RUN, pending_redirect=0, stall_cnt=0, flush_cnt=0, busy=0 immediately (asynchronous).
REQ-031 While rst=1 all load and flush outputs 0; reset mid-MEM_WAIT discards pending_redirect.
REQ-032 First cycle after rst release evaluated as RUN.

Structure
REQ-033 ctrl_state_t enum, pipe_ctrl_t struct (loads/flushes), NOP_INSTR constant belong in rv32i_types.
REQ-034 Counters built from one sub-module, sat_counter (CNT_W, inc, clr), instantiated twice.

Verification
REQ-035 No hazards, imem_resp=1, dmem_active=0 for 10 cycles -> all loads 1, stall_cnt=0.
REQ-036 dmem_active=1, dmem_resp=0 for 3 cycles then 1 -> loads 0 for 3 cycles, busy=1, stall_cnt=3, release cycle loads 1.
REQ-037 ex_is_load=1, ex_rd=5, id_rs2=5 -> pc_load=0, if_id_load=0, id_ex_flush=1 one cycle; ex_rd=0 -> no bubble.
REQ-038 br_taken_ex pulse during imem_resp=0 for 2 cycles -> no flush during stall, flush pair on release cycle, flush_cnt=1.
REQ-039 br_taken_ex with simultaneous load_use -> redirect only (flushes 1, pc_load=1), stall_cnt unchanged.
REQ-040 Preload counters near max (CNT_W=4), 20 stall cycles -> stall_cnt=15; rst asserted mid-MEM_WAIT -> outputs 0 immediately, pending cleared.

Source files
------------

// File: rtl/rv32i_types.sv
// rv32i_types: shared types and constants for the pipeline control slice
package rv32i_types;

    typedef enum logic {
        RUN      = 1'b0,
        MEM_WAIT = 1'b1
    } ctrl_state_t;

    typedef struct packed {
        logic pc_load;
        logic if_id_load;
        logic id_ex_load;
        logic ex_mem_load;
        logic mem_wb_load;
        logic if_id_flush;
        logic id_ex_flush;
    } pipe_ctrl_t;

    localparam logic [31:0] NOP_INSTR = 32'h0000_0013;

    localparam pipe_ctrl_t CTRL_HOLD   = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    localparam pipe_ctrl_t CTRL_RUN    = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    localparam pipe_ctrl_t CTRL_REDIR  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 1'b1};
    localparam pipe_ctrl_t CTRL_BUBBLE = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1};

endpackage

// File: rtl/sat_counter.sv
// sat_counter: event counter that sticks at all-ones, with synchronous clear
module sat_counter #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [CNT_W-1:0] cnt
);

    // clear wins over a same-cycle increment; saturate instead of wrapping
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt <= '0;
        else if (clr)
            cnt <= '0;
        else if (inc && cnt != '1)
            cnt <= cnt + CNT_W'(1);
    end

endmodule

// File: rtl/pipeline_ctrl.sv
// pipeline_ctrl: stall/flush/bubble control for a 5-stage pipeline with perf counters
module pipeline_ctrl
    import rv32i_types::*;
#(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             imem_resp,
    input  logic             dmem_active,
    input  logic             dmem_resp,
    input  logic             br_taken_ex,
    input  logic             ex_is_load,
    input  logic [4:0]       ex_rd,
    input  logic [4:0]       id_rs1,
    input  logic [4:0]       id_rs2,
    input  logic             clr_cnt,
    output logic             pc_load,
    output logic             if_id_load,
    output logic             id_ex_load,
    output logic             ex_mem_load,
    output logic             mem_wb_load,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             busy
);

    ctrl_state_t state, state_nxt;
    logic        pending, pending_nxt;
    pipe_ctrl_t  ctrl;

    logic mem_stall, load_use, redirect;

    assign mem_stall = ~imem_resp | (dmem_active & ~dmem_resp);
    assign load_use  = ex_is_load & (ex_rd != 5'd0) & ((ex_rd == id_rs1) | (ex_rd == id_rs2));
    assign redirect  = ~mem_stall & (br_taken_ex | pending);

    // state and deferred-redirect registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state   <= RUN;
            pending <= 1'b0;
        end else begin
            state   <= state_nxt;
            pending <= pending_nxt;
        end
    end

    // a taken branch seen during a stall is remembered until the stall lifts
    always_comb begin
        state_nxt   = mem_stall ? MEM_WAIT : RUN;
        pending_nxt = mem_stall & (pending | br_taken_ex);
    end

    // stage enables by priority: reset, memory stall, redirect, load-use bubble
    always_comb begin
        ctrl = rst       ? CTRL_HOLD   :
               mem_stall ? CTRL_HOLD   :
               redirect  ? CTRL_REDIR  :
               load_use  ? CTRL_BUBBLE : CTRL_RUN;
        busy = (state == MEM_WAIT);
    end

    assign pc_load     = ctrl.pc_load;
    assign if_id_load  = ctrl.if_id_load;
    assign id_ex_load  = ctrl.id_ex_load;
    assign ex_mem_load = ctrl.ex_mem_load;
    assign mem_wb_load = ctrl.mem_wb_load;
    assign if_id_flush = ctrl.if_id_flush;
    assign id_ex_flush = ctrl.id_ex_flush;

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk (clk),
        .rst (rst),
        .inc (~ctrl.pc_load),
        .clr (clr_cnt),
        .cnt (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk (clk),
        .rst (rst),
        .inc (ctrl.if_id_flush),
        .clr (clr_cnt),
        .cnt (flush_cnt)
    );

endmodule
